mem_stage: RTL and testbench

- Pipeline stage directly upstream of writeback: takes executed ops from execute and performs data-cache loads and stores.
- Aligns and extends load data, and registers the writeback payload: load data, ALU result, load/ALU select, destination register, PC and ecall flag.
- Stalls execute while a cache access is outstanding.

---
 rtl/mem_stage_pkg.sv | 46 ++++
 rtl/mem_stage_load_align.sv | 32 +++
 rtl/mem_stage.sv | 190 +++++++++++++++++++
 tb/tb_mem_stage.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: access-size encodings, FSM states,
// byte-enable patterns and the alignment rule.
package mem_stage_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_D  = 3'b011,
    F3_BU = 3'b100,
    F3_HU = 3'b101,
    F3_WU = 3'b110
  } funct3_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [7:0] WSTRB_B = 8'h01;
  localparam logic [7:0] WSTRB_H = 8'h03;
  localparam logic [7:0] WSTRB_W = 8'h0F;
  localparam logic [7:0] WSTRB_D = 8'hFF;

  function automatic logic is_aligned(input logic [2:0] f3, input logic [2:0] off);
    logic ok;
    case (f3)
      F3_H, F3_HU: ok = (off[0] == 1'b0);
      F3_W, F3_WU: ok = (off[1:0] == 2'b00);
      F3_D:        ok = (off == 3'b000);
      default:     ok = 1'b1;
    endcase
    return ok;
  endfunction

  function automatic logic [7:0] wstrb_base(input logic [2:0] f3);
    logic [7:0] strb;
    case (f3)
      F3_H, F3_HU: strb = WSTRB_H;
      F3_W, F3_WU: strb = WSTRB_W;
      F3_D:        strb = WSTRB_D;
      default:     strb = WSTRB_B;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Selects the addressed bytes of a returned doubleword and sign/zero extends
// them according to the access size.
module mem_stage_load_align
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] i_rdata,
  input  logic [2:0]      i_offset,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_lddata
);

  logic [XLEN-1:0] w_shifted;

  assign w_shifted = i_rdata >> {i_offset, 3'b000};

  always_comb begin
    // NOTE: default assignment first so every path drives o_lddata and no latch is inferred.
    o_lddata = w_shifted;
    case (i_funct3)
      F3_B:    o_lddata = {{(XLEN-8){w_shifted[7]}},   w_shifted[7:0]};
      F3_H:    o_lddata = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
      F3_W:    o_lddata = {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
      F3_BU:   o_lddata = {{(XLEN-8){1'b0}},  w_shifted[7:0]};
      F3_HU:   o_lddata = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
      F3_WU:   o_lddata = {{(XLEN-32){1'b0}}, w_shifted[31:0]};
      default: o_lddata = w_shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues data-cache loads/stores, stalls execute while an
// access is outstanding, and registers the writeback payload.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int REGBITS = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_ex_valid,
  input  logic [XLEN-1:0]    i_ex_alu_res,
  input  logic [XLEN-1:0]    i_ex_store_data,
  input  logic [REGBITS-1:0] i_ex_rd,
  input  logic               i_ex_is_load,
  input  logic               i_ex_is_store,
  input  logic [2:0]         i_ex_funct3,
  input  logic [31:0]        i_ex_pc,
  input  logic               i_ex_is_ecall,
  input  logic               i_flush,
  output logic               o_mem_stall,
  output logic               o_dc_req_valid,
  input  logic               i_dc_req_ready,
  output logic [XLEN-1:0]    o_dc_req_addr,
  output logic               o_dc_req_we,
  output logic [XLEN-1:0]    o_dc_req_wdata,
  output logic [7:0]         o_dc_req_wstrb,
  input  logic               i_dc_resp_valid,
  input  logic [XLEN-1:0]    i_dc_resp_rdata,
  output logic               o_wb_valid,
  output logic [XLEN-1:0]    o_wb_lddata,
  output logic [XLEN-1:0]    o_wb_alures,
  output logic               o_wb_ld_or_alu,
  output logic [REGBITS-1:0] o_wb_rd,
  output logic [31:0]        o_wb_pc,
  output logic               o_wb_is_ecall,
  output logic               o_misalign_err
);

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [XLEN-1:0]    r_addr;
  logic [XLEN-1:0]    r_wdata;
  logic [7:0]         r_wstrb;
  logic               r_we;
  logic [REGBITS-1:0] r_rd;
  logic [2:0]         r_funct3;
  logic [31:0]        r_pc;
  logic               r_ecall;
  logic               r_killed;

  logic               r_wb_valid;
  logic [XLEN-1:0]    r_wb_lddata;
  logic [XLEN-1:0]    r_wb_alures;
  logic               r_wb_ld_or_alu;
  logic [REGBITS-1:0] r_wb_rd;
  logic [31:0]        r_wb_pc;
  logic               r_wb_is_ecall;
  logic               r_misalign;

  logic               w_is_mem;
  logic               w_aligned;
  logic               w_accept;
  logic               w_start;
  logic               w_misalign;
  logic               w_alu_ret;
  logic               w_hs;
  logic               w_resp;
  logic               w_mem_ret;
  logic [XLEN-1:0]    w_lddata;

  assign w_is_mem   = i_ex_is_load | i_ex_is_store;
  assign w_aligned  = is_aligned(i_ex_funct3, i_ex_alu_res[2:0]);
  assign w_accept   = (r_state == ST_IDLE) & i_ex_valid & ~i_flush;
  assign w_start    = w_accept & w_is_mem & w_aligned;
  assign w_misalign = w_accept & w_is_mem & ~w_aligned;
  assign w_alu_ret  = w_accept & ~w_is_mem;
  assign w_hs       = (r_state == ST_REQ) & i_dc_req_ready;
  assign w_resp     = (r_state == ST_RESP) & i_dc_resp_valid;
  // A flush after the handshake cannot cancel the access; the result is just dropped.
  assign w_mem_ret  = w_resp & ~r_killed & ~i_flush;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = ST_REQ;
      ST_REQ: begin
        if (w_hs)         w_state_nxt = ST_RESP;
        else if (i_flush) w_state_nxt = ST_IDLE;
      end
      ST_RESP: if (i_dc_resp_valid) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_killed <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start)
        r_killed <= 1'b0;
      else if ((w_hs || r_state == ST_RESP) && i_flush)
        r_killed <= 1'b1;
    end
  end

  // NOTE: latched request fields are reset too, since they drive the cache request outputs directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_we     <= 1'b0;
      r_rd     <= '0;
      r_funct3 <= '0;
      r_pc     <= '0;
      r_ecall  <= 1'b0;
    end else if (w_start) begin
      r_addr   <= i_ex_alu_res;
      r_wdata  <= i_ex_store_data << {i_ex_alu_res[2:0], 3'b000};
      r_wstrb  <= i_ex_is_store ? (wstrb_base(i_ex_funct3) << i_ex_alu_res[2:0]) : 8'h00;
      r_we     <= i_ex_is_store;
      r_rd     <= i_ex_rd;
      r_funct3 <= i_ex_funct3;
      r_pc     <= i_ex_pc;
      r_ecall  <= i_ex_is_ecall;
    end
  end

  mem_stage_load_align #(.XLEN(XLEN)) u_load_align (
    .i_rdata  (i_dc_resp_rdata),
    .i_offset (r_addr[2:0]),
    .i_funct3 (r_funct3),
    .o_lddata (w_lddata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid     <= 1'b0;
      r_wb_lddata    <= '0;
      r_wb_alures    <= '0;
      r_wb_ld_or_alu <= 1'b0;
      r_wb_rd        <= '0;
      r_wb_pc        <= '0;
      r_wb_is_ecall  <= 1'b0;
      r_misalign     <= 1'b0;
    end else begin
      r_wb_valid <= w_alu_ret | w_misalign | w_mem_ret;
      r_misalign <= w_misalign;
      if (w_alu_ret || w_misalign) begin
        r_wb_alures    <= i_ex_alu_res;
        r_wb_pc        <= i_ex_pc;
        r_wb_is_ecall  <= i_ex_is_ecall;
        r_wb_ld_or_alu <= 1'b0;
        r_wb_rd        <= w_alu_ret ? i_ex_rd : '0;
      end else if (w_mem_ret) begin
        r_wb_alures    <= r_addr;
        r_wb_pc        <= r_pc;
        r_wb_is_ecall  <= r_ecall;
        r_wb_ld_or_alu <= ~r_we;
        r_wb_rd        <= r_we ? '0 : r_rd;
        if (!r_we) r_wb_lddata <= w_lddata;
      end else begin
        r_wb_rd <= '0;
      end
    end
  end

  // Stall is gated by reset so every output reads zero while reset is held.
  assign o_mem_stall    = rst_n & (w_start | (r_state == ST_REQ) |
                                   ((r_state == ST_RESP) & ~i_dc_resp_valid));
  assign o_dc_req_valid = (r_state == ST_REQ);
  assign o_dc_req_addr  = {r_addr[XLEN-1:3], 3'b000};
  assign o_dc_req_we    = r_we;
  assign o_dc_req_wdata = r_wdata;
  assign o_dc_req_wstrb = r_wstrb;

  assign o_wb_valid     = r_wb_valid;
  assign o_wb_lddata    = r_wb_lddata;
  assign o_wb_alures    = r_wb_alures;
  assign o_wb_ld_or_alu = r_wb_ld_or_alu;
  assign o_wb_rd        = r_wb_rd;
  assign o_wb_pc        = r_wb_pc;
  assign o_wb_is_ecall  = r_wb_is_ecall;
  assign o_misalign_err = r_misalign;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stimulus pushes expected writeback payloads into
// a scoreboard queue and a negedge monitor pops and compares on every wb_valid.
module tb_mem_stage;

  localparam int XLEN    = 64;
  localparam int REGBITS = 5;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               i_ex_valid;
  logic [XLEN-1:0]    i_ex_alu_res;
  logic [XLEN-1:0]    i_ex_store_data;
  logic [REGBITS-1:0] i_ex_rd;
  logic               i_ex_is_load;
  logic               i_ex_is_store;
  logic [2:0]         i_ex_funct3;
  logic [31:0]        i_ex_pc;
  logic               i_ex_is_ecall;
  logic               i_flush;
  logic               o_mem_stall;
  logic               o_dc_req_valid;
  logic               i_dc_req_ready;
  logic [XLEN-1:0]    o_dc_req_addr;
  logic               o_dc_req_we;
  logic [XLEN-1:0]    o_dc_req_wdata;
  logic [7:0]         o_dc_req_wstrb;
  logic               i_dc_resp_valid;
  logic [XLEN-1:0]    i_dc_resp_rdata;
  logic               o_wb_valid;
  logic [XLEN-1:0]    o_wb_lddata;
  logic [XLEN-1:0]    o_wb_alures;
  logic               o_wb_ld_or_alu;
  logic [REGBITS-1:0] o_wb_rd;
  logic [31:0]        o_wb_pc;
  logic               o_wb_is_ecall;
  logic               o_misalign_err;

  mem_stage #(.XLEN(XLEN), .REGBITS(REGBITS)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_ex_valid      (i_ex_valid),
    .i_ex_alu_res    (i_ex_alu_res),
    .i_ex_store_data (i_ex_store_data),
    .i_ex_rd         (i_ex_rd),
    .i_ex_is_load    (i_ex_is_load),
    .i_ex_is_store   (i_ex_is_store),
    .i_ex_funct3     (i_ex_funct3),
    .i_ex_pc         (i_ex_pc),
    .i_ex_is_ecall   (i_ex_is_ecall),
    .i_flush         (i_flush),
    .o_mem_stall     (o_mem_stall),
    .o_dc_req_valid  (o_dc_req_valid),
    .i_dc_req_ready  (i_dc_req_ready),
    .o_dc_req_addr   (o_dc_req_addr),
    .o_dc_req_we     (o_dc_req_we),
    .o_dc_req_wdata  (o_dc_req_wdata),
    .o_dc_req_wstrb  (o_dc_req_wstrb),
    .i_dc_resp_valid (i_dc_resp_valid),
    .i_dc_resp_rdata (i_dc_resp_rdata),
    .o_wb_valid      (o_wb_valid),
    .o_wb_lddata     (o_wb_lddata),
    .o_wb_alures     (o_wb_alures),
    .o_wb_ld_or_alu  (o_wb_ld_or_alu),
    .o_wb_rd         (o_wb_rd),
    .o_wb_pc         (o_wb_pc),
    .o_wb_is_ecall   (o_wb_is_ecall),
    .o_misalign_err  (o_misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [REGBITS-1:0] rd;
    logic [XLEN-1:0]    alures;
    logic [XLEN-1:0]    lddata;
    logic               ld_or_alu;
    logic [31:0]        pc;
    logic               ecall;
    logic               chk_ld;
  } wb_exp_t;

  wb_exp_t sb_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every wb_valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    wb_exp_t e;
    if (rst_n) begin
      if (o_wb_valid) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_wb: got wb_valid=1 with rd=%0d expected no retire", o_wb_rd);
        end else begin
          e = sb_q.pop_front();
          check("wb_rd", 64'(o_wb_rd), 64'(e.rd));
          check("wb_alures", o_wb_alures, e.alures);
          check("wb_ld_or_alu", 64'(o_wb_ld_or_alu), 64'(e.ld_or_alu));
          check("wb_pc", 64'(o_wb_pc), 64'(e.pc));
          check("wb_is_ecall", 64'(o_wb_is_ecall), 64'(e.ecall));
          if (e.chk_ld) check("wb_lddata", o_wb_lddata, e.lddata);
        end
      end else begin
        check("wb_rd_idle_zero", 64'(o_wb_rd), 64'd0);
      end
    end
  end

  task automatic idle_ex();
    i_ex_valid    = 1'b0;
    i_ex_is_load  = 1'b0;
    i_ex_is_store = 1'b0;
  endtask

  task automatic drive_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [63:0] a, input logic [63:0] sd,
                          input logic [4:0] rd, input logic [31:0] pc, input logic ecall);
    @(posedge clk); #1;
    i_ex_valid      = 1'b1;
    i_ex_is_load    = ld;
    i_ex_is_store   = st;
    i_ex_funct3     = f3;
    i_ex_alu_res    = a;
    i_ex_store_data = sd;
    i_ex_rd         = rd;
    i_ex_pc         = pc;
    i_ex_is_ecall   = ecall;
  endtask

  task automatic alu_op(input logic [63:0] a, input logic [4:0] rd,
                        input logic [31:0] pc, input logic ecall);
    wb_exp_t e;
    drive_op(1'b0, 1'b0, 3'b000, a, 64'd0, rd, pc, ecall);
    e = '{rd: rd, alures: a, lddata: 64'd0, ld_or_alu: 1'b0, pc: pc, ecall: ecall, chk_ld: 1'b0};
    sb_q.push_back(e);
    @(negedge clk);
    check("alu_stall", 64'(o_mem_stall), 64'd0);
    check("alu_no_req", 64'(o_dc_req_valid), 64'd0);
    @(posedge clk); #1;
    idle_ex();
  endtask

  task automatic check_req(input logic [63:0] addr, input logic we,
                           input logic [63:0] wdata, input logic [7:0] wstrb);
    check("req_valid", 64'(o_dc_req_valid), 64'd1);
    check("req_stall", 64'(o_mem_stall), 64'd1);
    check("req_addr", o_dc_req_addr, {addr[63:3], 3'b000});
    check("req_we", 64'(o_dc_req_we), 64'(we));
    if (we) begin
      check("req_wdata", o_dc_req_wdata, wdata);
      check("req_wstrb", 64'(o_dc_req_wstrb), 64'(wstrb));
    end
  endtask

  task automatic mem_op(input logic ld, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] sd, input logic [4:0] rd, input logic [31:0] pc,
                        input logic [63:0] rdata, input int ready_wait, input int resp_wait,
                        input logic [63:0] exp_wdata, input logic [7:0] exp_wstrb,
                        input logic [63:0] exp_ld, input logic flush_resp);
    wb_exp_t e;
    drive_op(ld, ~ld, f3, a, sd, rd, pc, 1'b0);
    @(negedge clk);
    check("start_stall", 64'(o_mem_stall), 64'd1);
    check("start_no_req", 64'(o_dc_req_valid), 64'd0);
    @(posedge clk); #1;
    for (int i = 0; i < ready_wait; i++) begin
      @(negedge clk);
      check_req(a, ~ld, exp_wdata, exp_wstrb);
      @(posedge clk); #1;
    end
    i_dc_req_ready = 1'b1;
    @(negedge clk);
    check_req(a, ~ld, exp_wdata, exp_wstrb);
    @(posedge clk); #1;
    i_dc_req_ready = 1'b0;
    if (flush_resp) i_flush = 1'b1;
    for (int i = 0; i < resp_wait; i++) begin
      @(negedge clk);
      check("resp_wait_stall", 64'(o_mem_stall), 64'd1);
      check("resp_wait_no_req", 64'(o_dc_req_valid), 64'd0);
      @(posedge clk); #1;
    end
    i_dc_resp_valid = 1'b1;
    i_dc_resp_rdata = rdata;
    if (!flush_resp) begin
      if (ld) e = '{rd: rd, alures: a, lddata: exp_ld, ld_or_alu: 1'b1, pc: pc, ecall: 1'b0, chk_ld: 1'b1};
      else    e = '{rd: 5'd0, alures: a, lddata: 64'd0, ld_or_alu: 1'b0, pc: pc, ecall: 1'b0, chk_ld: 1'b0};
      sb_q.push_back(e);
    end
    @(negedge clk);
    check("resp_stall_release", 64'(o_mem_stall), 64'd0);
    @(posedge clk); #1;
    i_dc_resp_valid = 1'b0;
    i_flush         = 1'b0;
    idle_ex();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end

  initial begin
    wb_exp_t e;
    rst_n           = 1'b0;
    i_flush         = 1'b0;
    i_dc_req_ready  = 1'b0;
    i_dc_resp_valid = 1'b0;
    i_dc_resp_rdata = '0;
    i_ex_alu_res    = '0;
    i_ex_store_data = '0;
    i_ex_rd         = '0;
    i_ex_funct3     = '0;
    i_ex_pc         = '0;
    i_ex_is_ecall   = 1'b0;
    idle_ex();
    repeat (2) @(negedge clk);
    check("rst_wb_valid", 64'(o_wb_valid), 64'd0);
    check("rst_req_valid", 64'(o_dc_req_valid), 64'd0);
    check("rst_stall", 64'(o_mem_stall), 64'd0);
    check("rst_wb_lddata", o_wb_lddata, 64'd0);
    check("rst_wb_alures", o_wb_alures, 64'd0);
    check("rst_misalign", 64'(o_misalign_err), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ALU ops, one carrying the ecall marker
    alu_op(64'h1234, 5'd5, 32'h0000_0100, 1'b0);
    alu_op(64'hFFFF_0000_0000_0001, 5'd31, 32'h0000_0104, 1'b1);

    // Loads: sign/zero extension across sizes and lanes
    mem_op(1'b1, 3'b000, 64'h1003, 64'd0, 5'd6, 32'h108, 64'h0000_0000_80FF_0000, 0, 0,
           64'd0, 8'h00, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    mem_op(1'b1, 3'b100, 64'h1003, 64'd0, 5'd7, 32'h10C, 64'h0000_0000_80FF_0000, 0, 0,
           64'd0, 8'h00, 64'h0000_0000_0000_0080, 1'b0);
    mem_op(1'b1, 3'b001, 64'h100A, 64'd0, 5'd8, 32'h110, 64'h0000_0000_8001_0000, 0, 0,
           64'd0, 8'h00, 64'hFFFF_FFFF_FFFF_8001, 1'b0);
    mem_op(1'b1, 3'b110, 64'h1004, 64'd0, 5'd9, 32'h114, 64'hDEAD_BEEF_0000_0000, 0, 0,
           64'd0, 8'h00, 64'h0000_0000_DEAD_BEEF, 1'b0);
    mem_op(1'b1, 3'b011, 64'h1008, 64'd0, 5'd10, 32'h118, 64'h1122_3344_5566_7788, 0, 0,
           64'd0, 8'h00, 64'h1122_3344_5566_7788, 1'b0);

    // Stores: lane shifting and byte enables
    mem_op(1'b0, 3'b001, 64'h1006, 64'hABCD, 5'd7, 32'h11C, 64'd0, 0, 0,
           64'hABCD_0000_0000_0000, 8'hC0, 64'd0, 1'b0);
    mem_op(1'b0, 3'b010, 64'h1014, 64'h1122_3344, 5'd0, 32'h120, 64'd0, 0, 0,
           64'h1122_3344_0000_0000, 8'hF0, 64'd0, 1'b0);
    mem_op(1'b0, 3'b011, 64'h1010, 64'h0123_4567_89AB_CDEF, 5'd0, 32'h124, 64'd0, 0, 0,
           64'h0123_4567_89AB_CDEF, 8'hFF, 64'd0, 1'b0);

    // Slow cache: ready held off 4 cycles, response 2 cycles after handshake
    mem_op(1'b1, 3'b010, 64'h2004, 64'd0, 5'd12, 32'h128, 64'h8765_4321_0000_0000, 4, 1,
           64'd0, 8'h00, 64'hFFFF_FFFF_8765_4321, 1'b0);

    // Misaligned word load
    drive_op(1'b1, 1'b0, 3'b010, 64'h1002, 64'd0, 5'd13, 32'h12C, 1'b0);
    e = '{rd: 5'd0, alures: 64'h1002, lddata: 64'd0, ld_or_alu: 1'b0, pc: 32'h12C, ecall: 1'b0, chk_ld: 1'b0};
    sb_q.push_back(e);
    @(negedge clk);
    check("mis_stall", 64'(o_mem_stall), 64'd0);
    check("mis_no_req", 64'(o_dc_req_valid), 64'd0);
    @(posedge clk); #1;
    idle_ex();
    @(negedge clk);
    check("mis_err_pulse", 64'(o_misalign_err), 64'd1);
    check("mis_no_req_after", 64'(o_dc_req_valid), 64'd0);
    @(negedge clk);
    check("mis_err_clear", 64'(o_misalign_err), 64'd0);

    // Flush while waiting for the response: result discarded
    mem_op(1'b1, 3'b011, 64'h3000, 64'd0, 5'd14, 32'h130, 64'h5555_5555_5555_5555, 0, 1,
           64'd0, 8'h00, 64'd0, 1'b1);
    @(negedge clk);
    check("flush_resp_wb_valid", 64'(o_wb_valid), 64'd0);
    check("flush_resp_wb_rd", 64'(o_wb_rd), 64'd0);
    alu_op(64'h4242, 5'd3, 32'h134, 1'b0);

    // Flush in REQ before the handshake: request withdrawn
    drive_op(1'b1, 1'b0, 3'b011, 64'h3008, 64'd0, 5'd15, 32'h138, 1'b0);
    @(posedge clk); #1;
    i_flush = 1'b1;
    @(negedge clk);
    check("flush_req_valid_before", 64'(o_dc_req_valid), 64'd1);
    @(posedge clk); #1;
    i_flush = 1'b0;
    idle_ex();
    @(negedge clk);
    check("flush_req_withdrawn", 64'(o_dc_req_valid), 64'd0);
    check("flush_req_stall", 64'(o_mem_stall), 64'd0);
    @(negedge clk);
    check("flush_req_no_wb", 64'(o_wb_valid), 64'd0);

    // Flush in IDLE drops the incoming op
    drive_op(1'b0, 1'b0, 3'b000, 64'h7777, 64'd0, 5'd4, 32'h13C, 1'b0);
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    idle_ex();
    @(negedge clk);
    check("flush_idle_no_wb", 64'(o_wb_valid), 64'd0);

    // Reset asserted mid-REQ, then a stray response must be ignored
    drive_op(1'b1, 1'b0, 3'b011, 64'h3010, 64'd0, 5'd16, 32'h140, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid_req_valid_before", 64'(o_dc_req_valid), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_req_valid", 64'(o_dc_req_valid), 64'd0);
    check("rst_mid_stall", 64'(o_mem_stall), 64'd0);
    check("rst_mid_wb_valid", 64'(o_wb_valid), 64'd0);
    check("rst_mid_wb_lddata", o_wb_lddata, 64'd0);
    check("rst_mid_wb_alures", o_wb_alures, 64'd0);
    check("rst_mid_wb_pc", 64'(o_wb_pc), 64'd0);
    check("rst_mid_req_addr", o_dc_req_addr, 64'd0);
    idle_ex();
    @(posedge clk); #1;
    rst_n = 1'b1;
    i_dc_resp_valid = 1'b1;
    i_dc_resp_rdata = 64'hAAAA_AAAA_AAAA_AAAA;
    @(posedge clk); #1;
    i_dc_resp_valid = 1'b0;
    @(negedge clk);
    check("rst_stray_resp_no_wb", 64'(o_wb_valid), 64'd0);
    alu_op(64'h9999, 5'd1, 32'h144, 1'b0);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
